// File: rtl/mod_enc_sub_shift_seq_if.sv
// mod_enc_sub_shift_seq_if: start/state request and state_out/busy/done result bundle
interface mod_enc_sub_shift_seq_if;
    logic         start;
    logic [127:0] state;
    logic [127:0] state_out;
    logic         busy;
    logic         done;
    modport master (output start, state, input state_out, busy, done);
    modport slave  (input start, state, output state_out, busy, done);
endinterface

// File: rtl/mod_enc_sub_shift_seq.sv
// mod_enc_sub_shift_seq: AES SubBytes+ShiftRows, LANES S-boxes time-multiplexed over 16 bytes
module mod_enc_sub_shift_seq #(
    parameter int LANES = 4
) (
    input logic                    clk,
    input logic                    reset,
    mod_enc_sub_shift_seq_if.slave bus
);
    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, BUSY} fsm_t;

    fsm_t                         fsm, fsm_nxt;
    logic [CW-1:0]                cnt;
    logic [N-1:0][8*LANES-1:0]    work, work_sub;
    logic [8*LANES-1:0]           grp_in, grp_out;
    logic [127:0]                 flat, shifted;
    logic                         last;

    // Entry b of the table sits at bit 2047-8b, i.e. {~b, 3'b111}
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    // Group 0 holds the MSB bytes, so it is the top word of the packed array
    assign last   = cnt == CW'(N - 1);
    assign grp_in = work[CW'(N - 1) - cnt];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign grp_out[8*i +: 8] = sbox(grp_in[8*i +: 8]);
    end

    // Working state with the current group already substituted
    always_comb begin
        work_sub = work;
        work_sub[CW'(N - 1) - cnt] = grp_out;
    end

    assign flat = work_sub;

    // ShiftRows as pure wiring: out(r,c) = sub(r,(c+r)%4), byte k = 4c + r
    for (genvar k = 0; k < 16; k++) begin : g_shift
        assign shifted[127 - 8*k -: 8] = flat[127 - 8*(4*(((k/4) + (k%4)) % 4) + (k%4)) -: 8];
    end

    assign bus.busy = fsm == BUSY;

    // Next-state: accept start only from IDLE, return to IDLE after the last group
    always_comb begin
        fsm_nxt = fsm;
        fsm_nxt = (fsm == IDLE) ? (bus.start ? BUSY : IDLE) : (last ? IDLE : BUSY);
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fsm <= IDLE;
        else        fsm <= fsm_nxt;
    end

    // Datapath: latch on start, substitute one group per cycle, publish on the last group
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            work          <= '0;
            bus.state_out <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= (fsm == BUSY) && last;
            if (fsm == IDLE && bus.start) begin
                work <= bus.state;
                cnt  <= '0;
            end else if (fsm == BUSY) begin
                work <= work_sub;
                cnt  <= last ? cnt : cnt + 1'b1;
                if (last) bus.state_out <= shifted;
            end
        end
    end
endmodule

// File: tb/tb_mod_enc_sub_shift_seq.sv
// tb_mod_enc_sub_shift_seq: scoreboard bench for SubBytes+ShiftRows across LANES values
module tb_mod_enc_sub_shift_seq;
    localparam logic [127:0] R1_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ORD_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ORD_OUT = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
    localparam logic [127:0] Z_OUT   = {16{8'h63}};

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] cur_exp;
    logic [127:0] q[$];
    logic [127:0] last_out;
    logic         prev_done;
    logic         prd_on;
    int           cyc;
    int           prev_cyc;
    int           errs;
    int           total;

    logic         p_start;
    logic [127:0] p_state;
    logic [4:0]   p_done;
    logic [127:0] p_out[5];

    mod_enc_sub_shift_seq_if bus();

    mod_enc_sub_shift_seq #(.LANES(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    for (genvar i = 0; i < 5; i++) begin : g_p
        mod_enc_sub_shift_seq_if pbus();
        mod_enc_sub_shift_seq #(.LANES(1 << i)) u (.clk(clk), .reset(reset), .bus(pbus.slave));
        assign pbus.start = p_start;
        assign pbus.state = p_state;
        assign p_done[i]  = pbus.done;
        assign p_out[i]   = pbus.state_out;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Push the expected result whenever the DUT accepts a start
    always @(posedge clk)
        if (reset && bus.start && !bus.busy) q.push_back(cur_exp);

    // Compare on done, enforce single-cycle done, and require state_out to hold otherwise
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            q.delete();
            last_out  = '0;
            prev_done = 1'b0;
        end else begin
            check("done_width", 128'(prev_done & bus.done), 128'd0);
            if (bus.done) begin
                check("queue_nonempty", 128'(q.size() != 0), 128'd1);
                if (q.size() != 0) check("result", bus.state_out, q.pop_front());
                if (prd_on && prev_cyc >= 0) check("period", 128'(cyc - prev_cyc), 128'd5);
                prev_cyc = cyc;
                last_out = bus.state_out;
            end else begin
                check("hold", bus.state_out, last_out);
            end
            prev_done = bus.done;
        end
    end

    task automatic run_block(input logic [127:0] v, input logic [127:0] e);
        int n;
        cur_exp   = e;
        bus.state = v;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.state = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 128'(n), 128'd4);
    endtask

    task automatic hs_block(input logic [127:0] v, input logic [127:0] e);
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_wait", 128'(bus.busy), 128'd0);
        bus.state = v;
        cur_exp   = e;
        @(posedge clk); #1;
        bus.state = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_params(input logic [127:0] v, input logic [127:0] e);
        int lat[5];
        for (int i = 0; i < 5; i++) lat[i] = 0;
        p_state = v;
        p_start = 1'b1;
        @(posedge clk); #1;
        p_start = 1'b0;
        p_state = '0;
        for (int m = 1; m <= 20; m++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 5; i++)
                if (p_done[i] && lat[i] == 0) lat[i] = m;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("lat_lanes%0d", 1 << i), 128'(lat[i]), 128'(16 >> i));
            check($sformatf("out_lanes%0d", 1 << i), p_out[i], e);
        end
    endtask

    initial begin
        errs = 0; total = 0; cyc = 0; prev_cyc = -1; prd_on = 1'b0;
        prev_done = 1'b0; last_out = '0; cur_exp = '0;
        reset = 1'b0; bus.start = 1'b0; bus.state = '0; p_start = 1'b0; p_state = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_out", bus.state_out, 128'd0);
        check("reset_done", 128'(bus.done), 128'd0);
        check("reset_busy", 128'(bus.busy), 128'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run_block(R1_IN, R1_OUT);
        run_block(ORD_IN, ORD_OUT);
        run_block('0, Z_OUT);
        repeat (3) @(posedge clk);
        #1;

        prd_on = 1'b1; prev_cyc = -1;
        bus.start = 1'b1;
        hs_block(R1_IN, R1_OUT);
        hs_block(ORD_IN, ORD_OUT);
        hs_block('0, Z_OUT);
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        prd_on = 1'b0;
        check("hs_drained", 128'(q.size()), 128'd0);

        cur_exp = R1_OUT; bus.state = R1_IN; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_out", bus.state_out, 128'd0);
        check("abort_done", 128'(bus.done), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_idle", 128'(bus.busy), 128'd0);
        run_block(ORD_IN, ORD_OUT);

        run_params(R1_IN, R1_OUT);
        run_params(ORD_IN, ORD_OUT);

        repeat (4) @(posedge clk);
        #1;
        check("final_drained", 128'(q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule
